// File: rtl/h_or_accum.sv
// ----------------------------------------------------------------------------
// h_or_accum
//
// Sequential OR-reduction engine. Words arrive on a valid/ready handshake and
// are ORed together over a frame. The frame closes when in_last is seen or
// when FRAME_LEN words have been taken. The result is then held on the output
// until the consumer accepts it.
//
// Two reduction modes, selected by the mode input on the first word of each
// frame:
//   mode 0 - bitwise accumulate: result is the word-wide OR of every word.
//   mode 1 - per-word reduce: bit k of the result is the OR of all bits of
//            word k, giving one flag bit per word of the frame.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   input word valid
//   in_ready   block can take a word (low only while a result is held)
//   in_data    input word, WIDTH bits
//   in_last    final word of the frame (early close)
//   mode       reduction mode, sampled on the first word of a frame
//   out_valid  result valid, held until out_ready
//   out_ready  consumer accepts the result
//   out_data   frame result, WIDTH bits
//   out_any    OR of out_data
//   out_count  number of words in the frame, CNT_W bits
// ----------------------------------------------------------------------------
module h_or_accum #(
    parameter int WIDTH     = 16,
    parameter int FRAME_LEN = 8,
    parameter int CNT_W     = $clog2(FRAME_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_any,
    output logic [CNT_W-1:0] out_count
);

    // Per-word reduce mode places one flag per word, so a frame can never be
    // longer than the word is wide.
    generate
        if (FRAME_LEN < 1 || FRAME_LEN > WIDTH) begin : g_bad_frame_len
            $error("h_or_accum: FRAME_LEN must be in 1..WIDTH");
        end
        if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
            $error("h_or_accum: WIDTH must be in 2..64");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } state_t;

    localparam logic [CNT_W-1:0] FRAME_LEN_C = CNT_W'(FRAME_LEN);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               mode_q, mode_d;

    logic               accept;
    logic               eff_mode;
    logic [WIDTH-1:0]   bit_map;
    logic [WIDTH-1:0]   contrib;
    logic [CNT_W-1:0]   cnt_next;

    // Contribution of the word being offered. On the first word of a frame
    // the live mode input applies, afterwards the mode captured with that
    // first word, so mid-frame mode changes have no effect. cnt_q is the
    // 0-based index of the word, and stays below FRAME_LEN <= WIDTH, so the
    // shifted flag always lands inside the word.
    always_comb begin
        accept   = in_valid && in_ready;
        eff_mode = (state_q == IDLE) ? mode : mode_q;
        bit_map  = {{(WIDTH-1){1'b0}}, |in_data} << cnt_q;
        contrib  = eff_mode ? bit_map : in_data;
        cnt_next = cnt_q + CNT_W'(1);
    end

    // Next-state logic. A frame closes on in_last or when the word count
    // reaches FRAME_LEN; either condition gives a single close. The result
    // registers are cleared when the consumer takes the result so the next
    // frame starts from zero.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    mode_d  = mode;
                    cnt_d   = CNT_W'(1);
                    acc_d   = contrib;
                    state_d = (in_last || FRAME_LEN == 1) ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    acc_d = acc_q | contrib;
                    cnt_d = cnt_next;
                    if (in_last || cnt_next == FRAME_LEN_C) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

    // All outputs come straight from registers. Input is refused for every
    // cycle a result is held, so there is no bypass between the two sides.
    // out_data shows the running accumulation; it is only meaningful while
    // out_valid is high.
    assign in_ready  = (state_q != HOLD);
    assign out_valid = (state_q == HOLD);
    assign out_data  = acc_q;
    assign out_any   = |acc_q;
    assign out_count = cnt_q;

endmodule

// File: tb/tb_h_or_accum.sv
// ----------------------------------------------------------------------------
// tb_h_or_accum
//
// Self-checking bench for h_or_accum. Two instances: the default 16-bit,
// 8-word build and a 4-bit build with single-word frames. Expected results
// are pushed to a queue when the frame is driven and popped when the block
// presents its result. Inputs change and outputs are sampled on the falling
// clock edge.
// ----------------------------------------------------------------------------
module tb_h_or_accum;

    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  count;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    // Signals of the default instance
    logic        in_valid, in_ready, in_last, mode;
    logic        out_valid, out_ready, out_any;
    logic [15:0] in_data, out_data;
    logic [3:0]  out_count;

    // Signals of the single-word-frame instance
    logic        s_in_valid, s_in_ready, s_in_last, s_mode;
    logic        s_out_valid, s_out_ready, s_out_any;
    logic [3:0]  s_in_data, s_out_data;
    logic [0:0]  s_out_count;

    exp_t exp_q[$];
    int   num_checks = 0;
    int   num_fail   = 0;

    always #5 clk = ~clk;

    h_or_accum #(.WIDTH(16), .FRAME_LEN(8)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_any   (out_any),
        .out_count (out_count)
    );

    h_or_accum #(.WIDTH(4), .FRAME_LEN(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .in_data   (s_in_data),
        .in_last   (s_in_last),
        .mode      (s_mode),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .out_data  (s_out_data),
        .out_any   (s_out_any),
        .out_count (s_out_count)
    );

    // Offer one word to the default instance starting at the next falling edge.
    task automatic drive_word(input logic [15:0] d, input logic last, input logic md);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        mode     = md;
    endtask

    // Wait, a bounded number of falling edges, for the default instance to
    // present a result.
    task automatic wait_out_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Reset state, asynchronous reset in the middle of a frame, and a clean
    // one-word frame after release.
    task automatic test_reset();
        exp_t e;
        bit   ok;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        in_last     = 1'b0;
        mode        = 1'b0;
        out_ready   = 1'b1;
        s_in_valid  = 1'b0;
        s_in_data   = '0;
        s_in_last   = 1'b0;
        s_mode      = 1'b0;
        s_out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        num_checks++;
        if ({out_valid, in_ready, out_data, out_count, out_any} !== {1'b0, 1'b1, 16'h0000, 4'd0, 1'b0}) begin
            num_fail++;
            $display("FAIL reset_state got valid=%b ready=%b data=%h count=%0d any=%b want 0 1 0000 0 0",
                     out_valid, in_ready, out_data, out_count, out_any);
        end
        drive_word(16'h0010, 1'b0, 1'b0);
        drive_word(16'h0020, 1'b0, 1'b0);
        drive_word(16'h0040, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        num_checks++;
        if ({out_valid, in_ready, out_data, out_count} !== {1'b0, 1'b1, 16'h0000, 4'd0}) begin
            num_fail++;
            $display("FAIL async_reset got valid=%b ready=%b data=%h count=%0d want 0 1 0000 0",
                     out_valid, in_ready, out_data, out_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        num_checks++;
        if (out_valid !== 1'b0) begin
            num_fail++;
            $display("FAIL no_result_after_reset got valid=%b want 0", out_valid);
        end
        exp_q.push_back('{data: 16'h0001, count: 4'd1});
        drive_word(16'h0001, 1'b1, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        wait_out_valid(ok);
        num_checks++;
        if (!ok || exp_q.size() == 0) begin
            num_fail++;
            $display("FAIL reset_frame_timeout got valid=%b want 1", out_valid);
        end else begin
            e = exp_q.pop_front();
            if ({out_data, out_count} !== {e.data, e.count}) begin
                num_fail++;
                $display("FAIL reset_frame got data=%h count=%0d want data=%h count=%0d",
                         out_data, out_count, e.data, e.count);
            end
        end
        @(negedge clk);
    endtask

    // Eight back-to-back words in mode 0, closed by the word count.
    task automatic test_full_frame();
        exp_t        e;
        logic [15:0] w;
        exp_q.push_back('{data: 16'h00FF, count: 4'd8});
        for (int i = 0; i < 8; i++) begin
            w = 16'h0001 << i;
            drive_word(w, 1'b0, 1'b0);
            if (i == 7) begin
                num_checks++;
                if (out_valid !== 1'b0) begin
                    num_fail++;
                    $display("FAIL full_early_valid got valid=%b after 7 words want 0", out_valid);
                end
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        num_checks++;
        if ({out_valid, in_ready} !== 2'b10) begin
            num_fail++;
            $display("FAIL full_latency got valid=%b ready=%b want 1 0", out_valid, in_ready);
        end
        num_checks++;
        if (exp_q.size() == 0) begin
            num_fail++;
            $display("FAIL full_result got empty scoreboard want entry");
        end else begin
            e = exp_q.pop_front();
            if ({out_data, out_count, out_any} !== {e.data, e.count, 1'b1}) begin
                num_fail++;
                $display("FAIL full_result got data=%h count=%0d any=%b want data=%h count=%0d any=1",
                         out_data, out_count, out_any, e.data, e.count);
            end
        end
        @(negedge clk);
        num_checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            num_fail++;
            $display("FAIL full_release got valid=%b ready=%b want 0 1", out_valid, in_ready);
        end
    endtask

    // Mode 1 frame closed early by in_last; mode input toggled mid-frame.
    task automatic test_early_close();
        exp_t e;
        exp_q.push_back('{data: 16'h000A, count: 4'd4});
        drive_word(16'h0000, 1'b0, 1'b1);
        drive_word(16'h0400, 1'b0, 1'b1);
        drive_word(16'h0000, 1'b0, 1'b0);
        drive_word(16'h8000, 1'b1, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        num_checks++;
        if (out_valid !== 1'b1 || exp_q.size() == 0) begin
            num_fail++;
            $display("FAIL early_valid got valid=%b want 1", out_valid);
        end else begin
            e = exp_q.pop_front();
            if ({out_data, out_count} !== {e.data, e.count}) begin
                num_fail++;
                $display("FAIL early_result got data=%h count=%0d want data=%h count=%0d",
                         out_data, out_count, e.data, e.count);
            end
        end
        @(negedge clk);
    endtask

    // Result held under backpressure while a new word waits; the waiting
    // word becomes the next frame once the result is taken.
    task automatic test_backpressure();
        exp_t e;
        bit   ok;
        out_ready = 1'b0;
        exp_q.push_back('{data: 16'h1234, count: 4'd1});
        drive_word(16'h1234, 1'b1, 1'b0);
        exp_q.push_back('{data: 16'h00F0, count: 4'd1});
        drive_word(16'h00F0, 1'b1, 1'b0);
        e = exp_q.pop_front();
        for (int k = 0; k < 5; k++) begin
            num_checks++;
            if ({out_valid, in_ready, out_data, out_count} !== {1'b1, 1'b0, e.data, e.count}) begin
                num_fail++;
                $display("FAIL bp_hold cycle %0d got valid=%b ready=%b data=%h count=%0d want 1 0 %h %0d",
                         k, out_valid, in_ready, out_data, out_count, e.data, e.count);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        num_checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            num_fail++;
            $display("FAIL bp_release got valid=%b ready=%b want 0 1", out_valid, in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        wait_out_valid(ok);
        num_checks++;
        if (!ok || exp_q.size() == 0) begin
            num_fail++;
            $display("FAIL bp_pending_timeout got valid=%b want 1", out_valid);
        end else begin
            e = exp_q.pop_front();
            if ({out_data, out_count} !== {e.data, e.count}) begin
                num_fail++;
                $display("FAIL bp_pending got data=%h count=%0d want data=%h count=%0d",
                         out_data, out_count, e.data, e.count);
            end
        end
        @(negedge clk);
    endtask

    // Eight zero words in mode 0.
    task automatic test_all_zero();
        exp_t e;
        exp_q.push_back('{data: 16'h0000, count: 4'd8});
        for (int i = 0; i < 8; i++) begin
            drive_word(16'h0000, 1'b0, 1'b0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        num_checks++;
        if (out_valid !== 1'b1 || exp_q.size() == 0) begin
            num_fail++;
            $display("FAIL zero_valid got valid=%b want 1", out_valid);
        end else begin
            e = exp_q.pop_front();
            if ({out_data, out_count, out_any} !== {e.data, e.count, 1'b0}) begin
                num_fail++;
                $display("FAIL zero_result got data=%h count=%0d any=%b want data=%h count=%0d any=0",
                         out_data, out_count, out_any, e.data, e.count);
            end
        end
        @(negedge clk);
    endtask

    // Single-word frames on the 4-bit instance: every accepted word closes
    // a frame of count 1.
    task automatic test_frame_len_one();
        exp_t       e;
        logic [3:0] words [3] = '{4'hA, 4'h0, 4'h6};
        logic       modes [3] = '{1'b1, 1'b1, 1'b0};
        logic [3:0] exps  [3] = '{4'h1, 4'h0, 4'h6};
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back('{data: {12'h000, exps[i]}, count: 4'd1});
            @(negedge clk);
            s_in_valid = 1'b1;
            s_in_data  = words[i];
            s_mode     = modes[i];
            s_in_last  = 1'b0;
            @(negedge clk);
            s_in_valid = 1'b0;
            num_checks++;
            if ({s_out_valid, s_in_ready} !== 2'b10 || exp_q.size() == 0) begin
                num_fail++;
                $display("FAIL f1_valid word %0d got valid=%b ready=%b want 1 0", i, s_out_valid, s_in_ready);
            end else begin
                e = exp_q.pop_front();
                if ({s_out_data, s_out_count} !== {e.data[3:0], e.count[0]}) begin
                    num_fail++;
                    $display("FAIL f1_result word %0d got data=%h count=%0d want data=%h count=%0d",
                             i, s_out_data, s_out_count, e.data[3:0], e.count);
                end
            end
            @(negedge clk);
            num_checks++;
            if (s_out_valid !== 1'b0) begin
                num_fail++;
                $display("FAIL f1_release word %0d got valid=%b want 0", i, s_out_valid);
            end
        end
    endtask

    // Run every scenario in order, then confirm the scoreboard drained.
    initial begin
        test_reset();
        test_full_frame();
        test_early_close();
        test_backpressure();
        test_all_zero();
        test_frame_len_one();
        num_checks++;
        if (exp_q.size() != 0) begin
            num_fail++;
            $display("FAIL scoreboard_drain got %0d entries left want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
        $finish;
    end

    // Guard against a run that never finishes.
    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
